hwag_core: RTL and testbench

HWAG_CORE -- requirements
Module: hwag_core

---
 rtl/hwag_pkg.sv | 23 ++
 rtl/hwag_capture.sv | 30 +++
 rtl/hwag_core.sv | 164 ++++++++++++++++
 tb/tb_hwag_core.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hwag_pkg.sv
// Shared constants and state type for the 60-2 crank angle generator.
package hwag_pkg;

    localparam int TEETH     = 58;
    localparam int GAP_TEETH = 2;
    localparam int SUB_W     = 6;

    localparam int TCNT_W    = 6;
    localparam int ANGLE_W   = 12;
    localparam int SUB_CNT_W = 8;

    localparam logic [TCNT_W-1:0]    LAST_TOOTH    = TCNT_W'(TEETH - 1);
    // The last tooth spans itself plus the missing teeth before the next edge.
    localparam logic [SUB_CNT_W-1:0] SUB_LIM_TOOTH = SUB_CNT_W'((1 << SUB_W) - 1);
    localparam logic [SUB_CNT_W-1:0] SUB_LIM_LAST  = SUB_CNT_W'(((GAP_TEETH + 1) << SUB_W) - 1);

    typedef enum logic [1:0] {
        ST_WAIT1,
        ST_SEARCH,
        ST_SYNC
    } hwag_state_t;

endpackage

// File: rtl/hwag_capture.sv
// Crank input synchronizer; emits a one-cycle tooth event on the selected edge.
module hwag_capture
    import hwag_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic cap,
    input  logic cap_edge_sel,
    output logic tooth_event
);

    logic sync1;
    logic sync2;
    logic sync_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            sync_d      <= 1'b0;
            tooth_event <= 1'b0;
        end else begin
            sync1       <= cap;
            sync2       <= sync1;
            sync_d      <= sync2;
            tooth_event <= cap_edge_sel ? (sync2 & ~sync_d) : (~sync2 & sync_d);
        end
    end

endmodule

// File: rtl/hwag_core.sv
// Hardware angle generator: measures tooth periods, locks onto the missing-tooth
// gap and interpolates angle between teeth.
module hwag_core
    import hwag_pkg::*;
#(
    parameter int PCNT_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cap,
    input  logic               cap_edge_sel,
    output logic               hwag_sync,
    output logic [TCNT_W-1:0]  hwag_tcnt,
    output logic [ANGLE_W-1:0] hwag_angle,
    output logic [PCNT_W-1:0]  hwag_period,
    output logic               hwag_err
);

    localparam int STEP_W = PCNT_W - SUB_W;

    logic                 tooth_event;
    hwag_state_t          state;
    hwag_state_t          state_next;
    logic                 armed;
    logic                 armed_next;
    logic [TCNT_W-1:0]    tcnt;
    logic [TCNT_W-1:0]    tcnt_next;
    logic                 err_next;
    logic [PCNT_W-1:0]    pcnt;
    logic [PCNT_W-1:0]    t_prev;
    logic [PCNT_W-1:0]    t_cur;
    logic                 gap;
    logic                 stall;
    logic                 period_valid;
    logic [SUB_CNT_W-1:0] sub;
    logic [SUB_CNT_W-1:0] sub_lim;
    logic [STEP_W-1:0]    step_cnt;
    logic [STEP_W-1:0]    step_len;

    hwag_capture u_capture (
        .clk          (clk),
        .rst          (rst),
        .cap          (cap),
        .cap_edge_sel (cap_edge_sel),
        .tooth_event  (tooth_event)
    );

    // Interval ending at this event, compared against the one before it.
    assign t_cur        = (&pcnt) ? pcnt : pcnt + 1'b1;
    assign gap          = {1'b0, t_cur} >= {t_prev, 1'b0};
    assign stall        = {2'b00, pcnt} > {t_prev, 2'b00};
    assign period_valid = (state != ST_WAIT1) || armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt        <= '0;
            t_prev      <= '0;
            hwag_period <= '0;
        end else if (tooth_event) begin
            pcnt <= '0;
            if (period_valid) begin
                t_prev <= t_cur;
                if (state == ST_WAIT1 || !gap) begin
                    hwag_period <= t_cur;
                end
            end
        end else if (!(&pcnt)) begin
            pcnt <= pcnt + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        armed_next = armed;
        tcnt_next  = tcnt;
        err_next   = 1'b0;
        case (state)
            ST_WAIT1: begin
                if (tooth_event) begin
                    if (armed) begin
                        state_next = ST_SEARCH;
                    end else begin
                        armed_next = 1'b1;
                    end
                end
            end
            ST_SEARCH: begin
                if (tooth_event) begin
                    if (gap) begin
                        state_next = ST_SYNC;
                        tcnt_next  = '0;
                    end
                end else if (stall) begin
                    state_next = ST_WAIT1;
                    armed_next = 1'b0;
                end
            end
            ST_SYNC: begin
                if (tooth_event) begin
                    if (gap && tcnt == LAST_TOOTH) begin
                        tcnt_next = '0;
                    end else if (!gap && tcnt != LAST_TOOTH) begin
                        tcnt_next = tcnt + 1'b1;
                    end else begin
                        err_next   = 1'b1;
                        state_next = ST_SEARCH;
                        tcnt_next  = '0;
                    end
                end else if (stall) begin
                    err_next   = 1'b1;
                    state_next = ST_WAIT1;
                    armed_next = 1'b0;
                    tcnt_next  = '0;
                end
            end
            default: begin
                state_next = ST_WAIT1;
                armed_next = 1'b0;
                tcnt_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_WAIT1;
            armed    <= 1'b0;
            tcnt     <= '0;
            hwag_err <= 1'b0;
        end else begin
            state    <= state_next;
            armed    <= armed_next;
            tcnt     <= tcnt_next;
            hwag_err <= err_next;
        end
    end

    // Sub-steps restart on every tooth and hold just short of the next edge.
    assign step_len = (hwag_period[PCNT_W-1:SUB_W] == '0) ? {{(STEP_W-1){1'b0}}, 1'b1}
                                                          : hwag_period[PCNT_W-1:SUB_W];
    assign sub_lim  = (tcnt == LAST_TOOTH) ? SUB_LIM_LAST : SUB_LIM_TOOTH;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub      <= '0;
            step_cnt <= '0;
        end else if (state != ST_SYNC || tooth_event) begin
            sub      <= '0;
            step_cnt <= '0;
        end else if (step_cnt + 1'b1 >= step_len) begin
            step_cnt <= '0;
            if (sub < sub_lim) begin
                sub <= sub + 1'b1;
            end
        end else begin
            step_cnt <= step_cnt + 1'b1;
        end
    end

    assign hwag_sync  = (state == ST_SYNC);
    assign hwag_tcnt  = hwag_sync ? tcnt : '0;
    assign hwag_angle = hwag_sync ? ({tcnt, {SUB_W{1'b0}}} + ANGLE_W'(sub)) : '0;

endmodule

// File: tb/tb_hwag_core.sv
// Bench for hwag_core: drives a 60-2 wheel with random pitch and compares
// against an event-level model of tooth counting, gap lock and angle.
module tb_hwag_core;
    import hwag_pkg::*;

    localparam int PCNT_W = 24;

    logic               clk = 1'b0;
    logic               rst;
    logic               cap;
    logic               cap_edge_sel;
    logic               hwag_sync;
    logic [TCNT_W-1:0]  hwag_tcnt;
    logic [ANGLE_W-1:0] hwag_angle;
    logic [PCNT_W-1:0]  hwag_period;
    logic               hwag_err;

    always #5 clk = ~clk;

    hwag_core #(.PCNT_W(PCNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .cap          (cap),
        .cap_edge_sel (cap_edge_sel),
        .hwag_sync    (hwag_sync),
        .hwag_tcnt    (hwag_tcnt),
        .hwag_angle   (hwag_angle),
        .hwag_period  (hwag_period),
        .hwag_err     (hwag_err)
    );

    int checks   = 0;
    int errors   = 0;
    int err_seen = 0;

    bit m_armed;
    bit m_valid;
    bit m_locked;
    int m_prev;
    int m_tooth;
    int m_period;
    int m_errs = 0;

    bit active_level;
    int wheel_pos;

    always @(negedge clk) begin
        if (hwag_err === 1'b1) err_seen++;
    end

    initial begin
        #1500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task model_reset();
        m_armed  = 1'b0;
        m_valid  = 1'b0;
        m_locked = 1'b0;
        m_prev   = 0;
        m_tooth  = 0;
        m_period = 0;
    endtask

    // A silent wheel for more than four periods drops everything back to the start.
    task model_stall(input int iv);
        if (m_valid && iv - 2 > 4 * m_prev) begin
            if (m_locked) m_errs++;
            m_locked = 1'b0;
            m_valid  = 1'b0;
            m_armed  = 1'b0;
        end
    endtask

    task automatic model_event(input int iv);
        bit gap;
        if (!m_valid) begin
            if (m_armed) begin
                m_valid  = 1'b1;
                m_prev   = iv;
                m_period = iv;
            end else begin
                m_armed = 1'b1;
            end
            return;
        end
        gap    = (iv >= 2 * m_prev);
        m_prev = iv;
        if (!gap) m_period = iv;
        if (!m_locked) begin
            if (gap) begin
                m_locked = 1'b1;
                m_tooth  = 0;
            end
        end else if (gap && m_tooth == TEETH - 1) begin
            m_tooth = 0;
        end else if (!gap && m_tooth < TEETH - 1) begin
            m_tooth++;
        end else begin
            m_locked = 1'b0;
            m_errs++;
        end
    endtask

    // Angle just before the next edge: linear interpolation clamped below the next edge.
    function automatic int exp_angle_before_edge(input int since);
        int step;
        int next_edge;
        int angle;
        if (!m_locked) return 0;
        step = m_period / 64;
        if (step < 1) step = 1;
        next_edge = (m_tooth == TEETH - 1) ? (TEETH + GAP_TEETH) * 64 : (m_tooth + 1) * 64;
        angle = m_tooth * 64 + (since - 4) / step;
        if (angle > next_edge - 1) angle = next_edge - 1;
        return angle;
    endfunction

    task applyStimulus(input int iv);
        repeat (iv / 2 - 4) @(negedge clk);
        cap = ~active_level;
        repeat (iv - iv / 2) @(negedge clk);
        model_stall(iv);
        checkOutput("angle_before_edge", 32'(hwag_angle), exp_angle_before_edge(iv));
        cap = active_level;
        repeat (4) @(negedge clk);
        #1;
        model_event(iv);
        checkOutput("sync", 32'(hwag_sync), 32'(m_locked));
        checkOutput("tcnt", 32'(hwag_tcnt), m_locked ? m_tooth : 0);
        checkOutput("angle_at_edge", 32'(hwag_angle), m_locked ? m_tooth * 64 : 0);
        checkOutput("period", 32'(hwag_period), m_period);
        checkOutput("err_pulses", err_seen, m_errs);
    endtask

    task wheel_teeth(input int n, input int pitch);
        for (int i = 0; i < n; i++) begin
            if (wheel_pos == TEETH - 1) begin
                applyStimulus(pitch * (GAP_TEETH + 1));
                wheel_pos = 0;
            end else begin
                applyStimulus(pitch);
                wheel_pos++;
            end
        end
    endtask

    task check_reset_outputs(input string phase);
        checkOutput({phase, "_sync"}, 32'(hwag_sync), 0);
        checkOutput({phase, "_tcnt"}, 32'(hwag_tcnt), 0);
        checkOutput({phase, "_angle"}, 32'(hwag_angle), 0);
        checkOutput({phase, "_period"}, 32'(hwag_period), 0);
        checkOutput({phase, "_err"}, 32'(hwag_err), 0);
    endtask

    initial begin
        int pitch;
        int p2;
        int p3;

        rst          = 1'b1;
        cap          = 1'b0;
        cap_edge_sel = 1'b1;
        active_level = 1'b1;
        model_reset();
        pitch = $urandom_range(128, 96);
        p2    = pitch * 17 / 16;
        p3    = p2 * 17 / 16;
        $display("[TB] base pitch %0d clk", pitch);
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Rising edges, starting mid-wheel: lock at the first post-gap tooth.
        wheel_pos = 40;
        wheel_teeth(18, pitch);
        checkOutput("lock_sync", 32'(hwag_sync), 1);
        checkOutput("lock_tcnt", 32'(hwag_tcnt), 0);
        checkOutput("lock_period", 32'(hwag_period), pitch);
        wheel_teeth(60, pitch);

        // Engine slowing revolution by revolution.
        wheel_teeth(TEETH, p2);
        wheel_teeth(TEETH, p3);
        checkOutput("slow_sync", 32'(hwag_sync), 1);
        checkOutput("slow_period", 32'(hwag_period), p3);

        // Spurious long interval at tooth 30.
        while (wheel_pos != 30) wheel_teeth(1, pitch);
        applyStimulus(pitch * (GAP_TEETH + 1));
        wheel_pos++;
        checkOutput("extra_gap_sync", 32'(hwag_sync), 0);
        while (wheel_pos != 0) wheel_teeth(1, pitch);
        checkOutput("resync_sync", 32'(hwag_sync), 1);
        checkOutput("resync_tcnt", 32'(hwag_tcnt), 0);

        // Wheel stops for six pitches mid-revolution.
        wheel_teeth(10, pitch);
        applyStimulus(pitch * 6);
        wheel_pos++;
        checkOutput("stall_sync", 32'(hwag_sync), 0);
        while (wheel_pos != 0) wheel_teeth(1, pitch);
        checkOutput("stall_resync", 32'(hwag_sync), 1);
        wheel_teeth(3, pitch);

        // Asynchronous reset in the middle of a tooth.
        repeat (20) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        model_reset();

        // Falling-edge selection on the same wheel pattern.
        cap_edge_sel = 1'b0;
        active_level = 1'b0;
        cap          = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wheel_pos = 45;
        wheel_teeth(13, pitch);
        checkOutput("falling_sync", 32'(hwag_sync), 1);
        checkOutput("falling_tcnt", 32'(hwag_tcnt), 0);
        wheel_teeth(20, pitch);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
